// File: rtl/pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_seq
// Description : Clock-wizard reset/lock sequencer. Pulses the wizard reset,
//               qualifies the synchronised 'locked' status over a stable
//               window and releases a clean system reset. Optional retry
//               limit with a terminal FAIL state via RST_SEQ_RETRY_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_rst_seq #(
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOSS_CNT_W       = 8,
    parameter int MAX_RETRY        = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  locked,
    output logic                  pll_rst,
    output logic                  rst_n_out,
    output logic                  lock_ok,
    output logic                  timeout_err,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                  fail
);

    localparam int c_PLL_W = $clog2(PLL_RST_CYC + 1);
    localparam int c_STB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int c_TMO_W = $clog2(LOCK_TIMEOUT_CYC + 1);

    localparam logic [c_PLL_W-1:0]    c_PLL_LAST = c_PLL_W'(PLL_RST_CYC - 1);
    localparam logic [c_STB_W-1:0]    c_STB_LAST = c_STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_STB_W-1:0]    c_STB_ONE  = c_STB_W'(1);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST = c_TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [LOSS_CNT_W-1:0] c_LOSS_MAX = '1;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_locked_s;
    logic [c_PLL_W-1:0]      r_pll_cnt;
    logic [c_PLL_W-1:0]      w_pll_cnt_nxt;
    logic [c_TMO_W-1:0]      r_tmo_cnt;
    logic [c_TMO_W-1:0]      w_tmo_cnt_nxt;
    logic [c_STB_W-1:0]      r_stb_cnt;
    logic [c_STB_W-1:0]      w_stb_cnt_nxt;
    logic [LOSS_CNT_W-1:0]   r_loss_cnt;
    logic [LOSS_CNT_W-1:0]   w_loss_nxt;
    logic                    w_timeout;
    logic                    r_pll_rst;
    logic                    r_rst_n_out;
    logic                    r_lock_ok;
    logic                    r_timeout_err;

`ifdef RST_SEQ_RETRY_LIMIT_EN
    localparam int                 c_RETRY_W    = $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_LAST = c_RETRY_W'(MAX_RETRY - 1);
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_retry_nxt;
    logic                 r_fail;
`endif

    // 'locked' is asynchronous to sys_clk; only the last stage is ever used
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt   = r_state;
        w_pll_cnt_nxt = r_pll_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_stb_cnt_nxt = r_stb_cnt;
        w_loss_nxt    = r_loss_cnt;
        w_timeout     = 1'b0;
`ifdef RST_SEQ_RETRY_LIMIT_EN
        w_retry_nxt   = r_retry;
`endif
        case (r_state)
            ST_PLL_RST: begin
                if (r_pll_cnt == c_PLL_LAST) begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_pll_cnt_nxt = '0;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    w_pll_cnt_nxt = r_pll_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle
                if (w_locked_s) begin
                    w_tmo_cnt_nxt = '0;
                    if (LOCK_STABLE_CYC == 1) begin
                        w_state_nxt   = ST_RUN;
                        w_stb_cnt_nxt = '0;
`ifdef RST_SEQ_RETRY_LIMIT_EN
                        w_retry_nxt   = '0;
`endif
                    end else begin
                        w_state_nxt   = ST_STABLE;
                        w_stb_cnt_nxt = c_STB_ONE;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout     = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_pll_cnt_nxt = '0;
`ifdef RST_SEQ_RETRY_LIMIT_EN
                    if (r_retry == c_RETRY_LAST) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_state_nxt = ST_PLL_RST;
                        w_retry_nxt = r_retry + 1'b1;
                    end
`else
                    w_state_nxt   = ST_PLL_RST;
`endif
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_tmo_cnt_nxt = '0;
                    w_stb_cnt_nxt = '0;
                end else if (r_stb_cnt == c_STB_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_stb_cnt_nxt = '0;
`ifdef RST_SEQ_RETRY_LIMIT_EN
                    w_retry_nxt   = '0;
`endif
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Loss of lock re-qualifies without pulsing the wizard reset
                if (!w_locked_s) begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_tmo_cnt_nxt = '0;
                    if (r_loss_cnt != c_LOSS_MAX) begin
                        w_loss_nxt = r_loss_cnt + 1'b1;
                    end
                end
            end
`ifdef RST_SEQ_RETRY_LIMIT_EN
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
`endif
            default: begin
                w_state_nxt   = ST_PLL_RST;
                w_pll_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_PLL_RST;
            r_pll_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_stb_cnt     <= '0;
            r_loss_cnt    <= '0;
            r_pll_rst     <= 1'b1;
            r_rst_n_out   <= 1'b0;
            r_lock_ok     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pll_cnt     <= w_pll_cnt_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_stb_cnt     <= w_stb_cnt_nxt;
            r_loss_cnt    <= w_loss_nxt;
            r_pll_rst     <= (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAIL);
            r_rst_n_out   <= (w_state_nxt == ST_RUN);
            r_lock_ok     <= (w_state_nxt == ST_RUN);
            r_timeout_err <= w_timeout;
        end
    end

`ifdef RST_SEQ_RETRY_LIMIT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_retry <= '0;
            r_fail  <= 1'b0;
        end else begin
            r_retry <= w_retry_nxt;
            r_fail  <= (w_state_nxt == ST_FAIL);
        end
    end

    assign fail = r_fail;
`else
    assign fail = 1'b0;
`endif

    assign pll_rst       = r_pll_rst;
    assign rst_n_out     = r_rst_n_out;
    assign lock_ok       = r_lock_ok;
    assign timeout_err   = r_timeout_err;
    assign lock_loss_cnt = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_rst_seq
// Description : Directed self-checking bench for pll_lock_rst_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_rst_seq;

    localparam int SYNC_STAGES      = 2;
    localparam int PLL_RST_CYC      = 4;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int LOCK_TIMEOUT_CYC = 32;
    localparam int LOSS_CNT_W       = 8;
`ifdef RST_SEQ_RETRY_LIMIT_EN
    localparam int MAX_RETRY        = 2;
`else
    localparam int MAX_RETRY        = 4;
`endif

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n;
    logic                  locked;
    logic                  pll_rst;
    logic                  rst_n_out;
    logic                  lock_ok;
    logic                  timeout_err;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic                  fail;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_rst_seq #(
        .SYNC_STAGES     (SYNC_STAGES),
        .PLL_RST_CYC     (PLL_RST_CYC),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .LOSS_CNT_W      (LOSS_CNT_W),
        .MAX_RETRY       (MAX_RETRY)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .rst_n_out    (rst_n_out),
        .lock_ok      (lock_ok),
        .timeout_err  (timeout_err),
        .lock_loss_cnt(lock_loss_cnt),
        .fail         (fail)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the DUT just released, 1 time unit after a rising edge
    task automatic apply_reset(input logic lk);
        sys_rst_n = 1'b0;
        locked    = lk;
        repeat (2) tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        locked    = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        n_tests++; if (rst_n_out !== 1'b0) begin n_fail++; $display("FAIL reset_rst_n_out: got %b want 0", rst_n_out); end
        n_tests++; if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL reset_lock_ok: got %b want 0", lock_ok); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_tests++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt); end
        n_tests++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail); end
        repeat (2) tick();
        n_tests++; if (pll_rst !== 1'b1 || rst_n_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: pll_rst=%b rst_n_out=%b want 1/0", pll_rst, rst_n_out);
        end
    endtask

    task automatic test_lock_seq();
        sys_rst_n = 1'b1;
        locked    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++; if (pll_rst !== (k < 4)) begin
                n_fail++; $display("FAIL lock_seq_pll_rst k=%0d: got %b want %b", k, pll_rst, (k < 4));
            end
        end
        repeat (6) tick();
        locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++; if (rst_n_out !== (k == 10)) begin
                n_fail++; $display("FAIL lock_seq_release k=%0d: got %b want %b", k, rst_n_out, (k == 10));
            end
        end
        n_tests++; if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL lock_seq_lock_ok: got %b want 1", lock_ok); end
        n_tests++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_seq_loss: got %0d want 0", lock_loss_cnt); end
        n_tests++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL lock_seq_pll_rst_run: got %b want 0", pll_rst); end
    endtask

    task automatic test_stable_drop();
        apply_reset(1'b0);
        repeat (6) tick();
        locked = 1'b1;
        repeat (6) tick();
        locked = 1'b0;
        repeat (2) tick();
        locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++; if (rst_n_out !== (k == 10)) begin
                n_fail++; $display("FAIL stable_drop_release k=%0d: got %b want %b", k, rst_n_out, (k == 10));
            end
        end
        n_tests++; if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL stable_drop_lock_ok: got %b want 1", lock_ok); end
    endtask

    task automatic test_run_loss();
        locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++; if (rst_n_out !== (k < 3)) begin
                n_fail++; $display("FAIL run_loss_fall k=%0d: got %b want %b", k, rst_n_out, (k < 3));
            end
        end
        n_tests++; if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL run_loss_lock_ok: got %b want 0", lock_ok); end
        n_tests++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL run_loss_cnt: got %0d want 1", lock_loss_cnt); end
        repeat (2) tick();
        locked = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            n_tests++; if (pll_rst !== 1'b0) begin
                n_fail++; $display("FAIL run_loss_no_pll_rst j=%0d: got %b want 0", j, pll_rst);
            end
            n_tests++; if (rst_n_out !== (j == 10)) begin
                n_fail++; $display("FAIL run_loss_rerelease j=%0d: got %b want %b", j, rst_n_out, (j == 10));
            end
        end
    endtask

    task automatic test_timeout();
        logic exp_te, exp_pr, exp_fl;
        apply_reset(1'b0);
        for (int k = 1; k <= 80; k++) begin
            tick();
            exp_te = (k == 36) || (k == 72);
`ifdef RST_SEQ_RETRY_LIMIT_EN
            exp_pr = (k < 4) || (k >= 36 && k < 40) || (k >= 72);
            exp_fl = (k >= 72);
`else
            exp_pr = (k < 4) || (k >= 36 && k < 40) || (k >= 72 && k < 76);
            exp_fl = 1'b0;
`endif
            n_tests++; if (timeout_err !== exp_te) begin
                n_fail++; $display("FAIL timeout_err k=%0d: got %b want %b", k, timeout_err, exp_te);
            end
            n_tests++; if (pll_rst !== exp_pr) begin
                n_fail++; $display("FAIL timeout_pll_rst k=%0d: got %b want %b", k, pll_rst, exp_pr);
            end
            n_tests++; if (fail !== exp_fl || rst_n_out !== 1'b0) begin
                n_fail++; $display("FAIL timeout_fail k=%0d: fail=%b rst_n_out=%b want %b/0", k, fail, rst_n_out, exp_fl);
            end
        end
    endtask

    task automatic test_saturation();
        int w;
        int n_stuck;
        apply_reset(1'b1);
        w = 0;
        while (rst_n_out !== 1'b1 && w < 30) begin tick(); w++; end
        n_tests++; if (rst_n_out !== 1'b1) begin n_fail++; $display("FAIL sat_initial_run: got %b want 1", rst_n_out); end
        n_stuck = 0;
        for (int i = 1; i <= 300; i++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            w = 0;
            while (rst_n_out !== 1'b0 && w < 10) begin tick(); w++; end
            if (rst_n_out !== 1'b0) n_stuck++;
            w = 0;
            while (rst_n_out !== 1'b1 && w < 20) begin tick(); w++; end
            if (rst_n_out !== 1'b1) n_stuck++;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                n_tests++; if (lock_loss_cnt !== LOSS_CNT_W'((i > 255) ? 255 : i)) begin
                    n_fail++; $display("FAIL sat_loss_cnt i=%0d: got %0d want %0d", i, lock_loss_cnt, (i > 255) ? 255 : i);
                end
            end
        end
        n_tests++; if (n_stuck != 0) begin n_fail++; $display("FAIL sat_relock: %0d expired waits, want 0", n_stuck); end
    endtask

    task automatic test_async_reset();
        #3;
        sys_rst_n = 1'b0;
        #1;
        n_tests++; if (rst_n_out !== 1'b0 || pll_rst !== 1'b1) begin
            n_fail++; $display("FAIL async_rst_outputs: rst_n_out=%b pll_rst=%b want 0/1", rst_n_out, pll_rst);
        end
        n_tests++; if (lock_ok !== 1'b0 || lock_loss_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_rst_state: lock_ok=%b loss=%0d want 0/0", lock_ok, lock_loss_cnt);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++; if (pll_rst !== (k < 4)) begin
                n_fail++; $display("FAIL async_rst_pll_rst k=%0d: got %b want %b", k, pll_rst, (k < 4));
            end
            n_tests++; if (rst_n_out !== (k == 12)) begin
                n_fail++; $display("FAIL async_rst_release k=%0d: got %b want %b", k, rst_n_out, (k == 12));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_seq();
        test_stable_drop();
        test_run_loss();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
